// File: rtl/fp_param_bank.sv
// Channel-addressed parameter shadow bank: host words land in a shadow store and a commit streams
// every dirty (channel, parameter) entry downstream. Optional readback port: FP_PARAM_READBACK_EN.
module fp_param_bank #(
  parameter int unsigned N_CHAN  = 8,
  parameter int unsigned N_PARAM = 8,
  parameter int unsigned W_DATA  = 48,
  parameter int unsigned W_WORD  = 16,
  parameter int unsigned W_CIDX  = 3,
  parameter int unsigned W_PIDX  = 3
) (
  input  logic              clk50_in,
  input  logic              reset_in,
  input  logic              wr_en_in,
  input  logic [W_CIDX-1:0] wr_chan_in,
  input  logic [W_PIDX-1:0] wr_param_in,
  input  logic [1:0]        wr_word_in,
  input  logic [W_WORD-1:0] wr_data_in,
  input  logic              commit_in,
  output logic              upd_valid_out,
  input  logic              upd_ready_in,
  output logic [W_CIDX-1:0] upd_chan_out,
  output logic [W_PIDX-1:0] upd_param_out,
  output logic [W_DATA-1:0] upd_data_out,
  output logic              busy_out,
  output logic              done_out,
`ifdef FP_PARAM_READBACK_EN
  input  logic [W_CIDX-1:0] rd_chan_in,
  input  logic [W_PIDX-1:0] rd_param_in,
  input  logic [1:0]        rd_word_in,
  output logic [W_WORD-1:0] rd_data_out,
`endif
  output logic              wr_err_out
);

  localparam int unsigned N_WORDS = W_DATA / W_WORD;
  localparam int unsigned N_ENT   = N_CHAN * N_PARAM;
  localparam int unsigned W_IDX   = W_CIDX + W_PIDX;

  typedef enum logic [1:0] {StIdle, StScan, StEmit, StDone} state_t;

  state_t              r_state;
  logic [W_DATA-1:0]   r_shadow [N_ENT];
  logic [N_ENT-1:0]    r_dirty;
  logic [W_IDX-1:0]    r_idx;
  logic                r_pending;
  logic                r_valid;
  logic [W_CIDX-1:0]   r_chan;
  logic [W_PIDX-1:0]   r_param;
  logic [W_DATA-1:0]   r_data;
  logic                r_busy;
  logic                r_done;
  logic                r_wr_err;

  logic                w_wr_ok;
  logic [W_IDX-1:0]    w_wr_idx;
  logic                w_last;

  assign w_wr_ok  = wr_en_in && (32'(wr_word_in) < N_WORDS);
  assign w_wr_idx = {wr_chan_in, wr_param_in};
  assign w_last   = (r_idx == W_IDX'(N_ENT - 1));

  always_ff @(posedge clk50_in) begin
    if (reset_in) begin
      for (int e = 0; e < int'(N_ENT); e++) r_shadow[e] <= '0;
    end else if (w_wr_ok) begin
      for (int w = 0; w < int'(N_WORDS); w++) begin
        if (32'(wr_word_in) == 32'(w)) r_shadow[w_wr_idx][w*W_WORD +: W_WORD] <= wr_data_in;
      end
    end
  end

  always_ff @(posedge clk50_in) begin
    if (reset_in) begin
      r_wr_err <= 1'b0;
    end else if (wr_en_in && !w_wr_ok) begin
      r_wr_err <= 1'b1;
    end
  end

  always_ff @(posedge clk50_in) begin
    if (reset_in) begin
      r_state   <= StIdle;
      r_dirty   <= '0;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_valid   <= 1'b0;
      r_chan    <= '0;
      r_param   <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (commit_in) begin
            r_state <= StScan;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        StScan: begin
          if (r_dirty[r_idx]) begin
            // Snapshot is taken here; a write on this edge updates the store, not the output.
            r_chan         <= r_idx[W_IDX-1:W_PIDX];
            r_param        <= r_idx[W_PIDX-1:0];
            r_data         <= r_shadow[r_idx];
            r_dirty[r_idx] <= 1'b0;
            r_valid        <= 1'b1;
            r_state        <= StEmit;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StEmit: begin
          if (upd_ready_in) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= StScan;
            end
          end
        end
        StDone: begin
          r_done <= 1'b0;
          // A commit arriving in this very cycle is folded into the pending rescan.
          if (r_pending || commit_in) begin
            r_pending <= 1'b0;
            r_idx     <= '0;
            r_state   <= StScan;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase

      if (commit_in && (r_state == StScan || r_state == StEmit)) r_pending <= 1'b1;
      // Placed after the scan clear so a same-edge write keeps the entry dirty.
      if (w_wr_ok) r_dirty[w_wr_idx] <= 1'b1;
    end
  end

`ifdef FP_PARAM_READBACK_EN
  logic [W_WORD-1:0] r_rd_data;

  always_ff @(posedge clk50_in) begin
    if (reset_in) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= '0;
      for (int w = 0; w < int'(N_WORDS); w++) begin
        if (32'(rd_word_in) == 32'(w)) begin
          r_rd_data <= r_shadow[{rd_chan_in, rd_param_in}][w*W_WORD +: W_WORD];
        end
      end
    end
  end

  assign rd_data_out = r_rd_data;
`endif

  assign upd_valid_out = r_valid;
  assign upd_chan_out  = r_chan;
  assign upd_param_out = r_param;
  assign upd_data_out  = r_data;
  assign busy_out      = r_busy;
  assign done_out      = r_done;
  assign wr_err_out    = r_wr_err;

endmodule

// File: tb/tb_fp_param_bank.sv
// Scoreboard bench for fp_param_bank: expected entries are queued when written and popped on each
// valid/ready handshake.
module tb_fp_param_bank;

  logic        clk50_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        wr_en_in = 1'b0;
  logic [2:0]  wr_chan_in = '0;
  logic [2:0]  wr_param_in = '0;
  logic [1:0]  wr_word_in = '0;
  logic [15:0] wr_data_in = '0;
  logic        commit_in = 1'b0;
  logic        upd_valid_out;
  logic        upd_ready_in = 1'b0;
  logic [2:0]  upd_chan_out;
  logic [2:0]  upd_param_out;
  logic [47:0] upd_data_out;
  logic        busy_out;
  logic        done_out;
  logic        wr_err_out;

  typedef struct packed {
    logic [2:0]  chan;
    logic [2:0]  param;
    logic [47:0] data;
  } exp_t;

  exp_t q_exp[$];
  int   n_err = 0;
  int   n_chk = 0;
  int   n_emit = 0;

  fp_param_bank dut (
    .clk50_in      (clk50_in),
    .reset_in      (reset_in),
    .wr_en_in      (wr_en_in),
    .wr_chan_in    (wr_chan_in),
    .wr_param_in   (wr_param_in),
    .wr_word_in    (wr_word_in),
    .wr_data_in    (wr_data_in),
    .commit_in     (commit_in),
    .upd_valid_out (upd_valid_out),
    .upd_ready_in  (upd_ready_in),
    .upd_chan_out  (upd_chan_out),
    .upd_param_out (upd_param_out),
    .upd_data_out  (upd_data_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .wr_err_out    (wr_err_out)
  );

  always #5 clk50_in = ~clk50_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted entry must match the head of the expected queue.
  always @(negedge clk50_in) begin
    if (!reset_in && upd_valid_out && upd_ready_in) begin
      n_emit++;
      if (q_exp.size() == 0) begin
        check_eq("spurious_emit", 64'(q_exp.size()), 64'd1);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        check_eq("emit_chan", 64'(upd_chan_out), 64'(e.chan));
        check_eq("emit_param", 64'(upd_param_out), 64'(e.param));
        check_eq("emit_data", 64'(upd_data_out), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk50_in);
    #1;
  endtask

  task automatic wr(input int ch, input int p, input int w, input logic [15:0] d);
    wr_en_in    = 1'b1;
    wr_chan_in  = 3'(ch);
    wr_param_in = 3'(p);
    wr_word_in  = 2'(w);
    wr_data_in  = d;
    tick();
    wr_en_in = 1'b0;
  endtask

  task automatic wr_entry(input int ch, input int p, input logic [47:0] v);
    for (int w = 0; w < 3; w++) wr(ch, p, w, v[w*16 +: 16]);
  endtask

  task automatic commit();
    commit_in = 1'b1;
    tick();
    commit_in = 1'b0;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    tick();
    tick();
    reset_in = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk50_in);
      if (done_out) begin
        cycles = k;
        break;
      end
    end
    if (cycles == 0) check_eq("done_timeout", 64'(cycles), 64'd1);
  endtask

  task automatic wait_valid();
    int seen;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk50_in);
      if (upd_valid_out) begin
        seen = 1;
        break;
      end
    end
    if (seen == 0) check_eq("valid_timeout", 64'(upd_valid_out), 64'd1);
  endtask

  initial begin
    int    cyc;
    int    emit0;
    exp_t  e;
    logic [47:0] va;
    logic [47:0] vb;

    // Reset state and a commit on a clean bank.
    do_reset();
    @(negedge clk50_in);
    check_eq("rst_valid", 64'(upd_valid_out), 64'd0);
    check_eq("rst_busy", 64'(busy_out), 64'd0);
    check_eq("rst_done", 64'(done_out), 64'd0);
    check_eq("rst_err", 64'(wr_err_out), 64'd0);
    check_eq("rst_data", 64'(upd_data_out), 64'd0);
    check_eq("rst_idx", 64'({upd_chan_out, upd_param_out}), 64'd0);
    upd_ready_in = 1'b1;
    tick();
    emit0 = n_emit;
    commit();
    wait_done(cyc);
    check_eq("clean_done_latency", 64'(cyc), 64'd65);
    @(negedge clk50_in);
    check_eq("clean_busy_after", 64'(busy_out), 64'd0);
    check_eq("clean_done_pulse", 64'(done_out), 64'd0);
    check_eq("clean_emit_count", 64'(n_emit - emit0), 64'd0);

    // Single entry assembled from three words.
    tick();
    wr(2, 1, 0, 16'h1111);
    wr(2, 1, 1, 16'h2222);
    wr(2, 1, 2, 16'h3333);
    e.chan = 3'd2; e.param = 3'd1; e.data = 48'h3333_2222_1111;
    q_exp.push_back(e);
    emit0 = n_emit;
    commit();
    wait_done(cyc);
    check_eq("single_emit_count", 64'(n_emit - emit0), 64'd1);
    check_eq("single_queue_left", 64'(q_exp.size()), 64'd0);

    // Backpressure on the first entry; order is index 0 then 63.
    tick();
    upd_ready_in = 1'b0;
    va = 48'hA5A5_0F0F_C3C3;
    wr_entry(0, 0, va);
    wr_entry(7, 7, 48'h7777_8888_9999);
    e.chan = 3'd0; e.param = 3'd0; e.data = va;
    q_exp.push_back(e);
    e.chan = 3'd7; e.param = 3'd7; e.data = 48'h7777_8888_9999;
    q_exp.push_back(e);
    emit0 = n_emit;
    commit();
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check_eq("hold_valid", 64'(upd_valid_out), 64'd1);
      check_eq("hold_idx", 64'({upd_chan_out, upd_param_out}), 64'd0);
      check_eq("hold_data", 64'(upd_data_out), 64'(va));
      @(negedge clk50_in);
    end
    @(posedge clk50_in);
    #1;
    upd_ready_in = 1'b1;
    wait_done(cyc);
    check_eq("bp_emit_count", 64'(n_emit - emit0), 64'd2);
    check_eq("bp_queue_left", 64'(q_exp.size()), 64'd0);

    // Rewrite ch0/p0 on the edge its dirty bit clears, with two commits while busy.
    tick();
    va = 48'h1234_5678_9ABC;
    wr_entry(0, 0, va);
    vb = {va[47:16], 16'hBEEF};
    e.chan = 3'd0; e.param = 3'd0; e.data = va;
    q_exp.push_back(e);
    e.data = vb;
    q_exp.push_back(e);
    emit0 = n_emit;
    commit();
    wr(0, 0, 0, 16'hBEEF);
    commit();
    commit();
    wait_done(cyc);
    check_eq("race_first_scan_emits", 64'(n_emit - emit0), 64'd1);
    wait_done(cyc);
    check_eq("race_rescan_emits", 64'(n_emit - emit0), 64'd2);
    for (int i = 0; i < 80; i++) @(negedge clk50_in);
    check_eq("race_single_rescan_busy", 64'(busy_out), 64'd0);
    check_eq("race_total_emits", 64'(n_emit - emit0), 64'd2);
    check_eq("race_queue_left", 64'(q_exp.size()), 64'd0);

    // Illegal word index sets the sticky error and dirties nothing.
    tick();
    wr(1, 1, 3, 16'h5555);
    @(negedge clk50_in);
    check_eq("err_set", 64'(wr_err_out), 64'd1);
    tick();
    emit0 = n_emit;
    commit();
    wait_done(cyc);
    check_eq("err_no_emit", 64'(n_emit - emit0), 64'd0);
    check_eq("err_sticky", 64'(wr_err_out), 64'd1);
    tick();
    do_reset();
    @(negedge clk50_in);
    check_eq("err_cleared", 64'(wr_err_out), 64'd0);

    // Reset while an entry waits for ready aborts the commit.
    tick();
    upd_ready_in = 1'b0;
    wr_entry(3, 4, 48'hDEAD_BEEF_CAFE);
    commit();
    wait_valid();
    check_eq("abort_pre_valid", 64'(upd_valid_out), 64'd1);
    tick();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    @(negedge clk50_in);
    check_eq("abort_valid", 64'(upd_valid_out), 64'd0);
    check_eq("abort_busy", 64'(busy_out), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("abort_no_done", 64'(done_out), 64'd0);
      @(negedge clk50_in);
    end
    upd_ready_in = 1'b1;
    tick();
    emit0 = n_emit;
    commit();
    wait_done(cyc);
    check_eq("abort_rescan_empty", 64'(n_emit - emit0), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
